// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DMEM_WIDTH    = 16;
    localparam int unsigned DMEM_ADDR_W   = 8;
    localparam int unsigned DMEM_LOCK_MAX = 8;
    // Wide enough for the largest legal LOCK_MAX (255).
    localparam int unsigned LOCK_CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // Ownership state for a given requester index.
    function automatic arb_state_e own_state(input logic who);
        return who ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin picker: a tie goes to the pointed-at requester.
module arb_rr_pick (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic       win_c_o,
    output logic       valid_c_o
);

    // Lone requester wins outright; on a tie the pointer decides.
    always_comb begin
        valid_c_o = |req_i;
        win_c_o   = (req_i == 2'b11) ? ptr_i : req_i[1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a CPU controller (0) and a host/debug loader (1) onto one
// synchronous-read data memory, with round-robin fairness and bounded lock.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned WIDTH    = DMEM_WIDTH,
    parameter int unsigned D_ADDR_W = DMEM_ADDR_W,
    parameter int unsigned LOCK_MAX = DMEM_LOCK_MAX
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [1:0]          lock,
    input  logic [1:0]          wr,
    input  logic [D_ADDR_W-1:0] addr0,
    input  logic [D_ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]    wdata0,
    input  logic [WIDTH-1:0]    wdata1,
    output logic [1:0]          gnt,
    output logic [1:0]          rvalid,
    output logic [WIDTH-1:0]    rdata,
    output logic [D_ADDR_W-1:0] mem_addr,
    output logic                mem_wr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata,
    output logic                busy
);

    localparam int unsigned CNT_INC_W = LOCK_CNT_W + 1;

    arb_state_e             state_q, state_d;
    logic [LOCK_CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_INC_W-1:0]   cnt_inc;
    logic                   ptr_q, ptr_d;
    logic [1:0]             gnt_q, gnt_d;
    logic [1:0]             rvalid_q, rvalid_d;
    logic                   busy_q, busy_d;

    logic                   owned;
    logic                   owner;
    logic                   other;
    logic                   xfer;
    logic                   pick_win;
    logic                   pick_valid;

    // Current owner and whether this cycle carries a transfer.
    always_comb begin
        owned = (state_q != IDLE);
        owner = (state_q == OWN1);
        other = ~owner;
        xfer  = owned & req[owner];
    end

    arb_rr_pick u_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .win_c_o   (pick_win),
        .valid_c_o (pick_valid)
    );

    // Next-state, lock counting, rr pointer and registered-output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        gnt_d    = 2'b00;
        rvalid_d = 2'b00;
        busy_d   = 1'b0;
        cnt_inc  = CNT_INC_W'(cnt_q) + CNT_INC_W'(1);

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = own_state(pick_win);
                end
            end
            OWN0, OWN1: begin
                if (xfer && lock[owner]) begin
                    // Locked transfer: hand over only once the run is spent
                    // and someone is actually waiting.
                    if ((cnt_inc >= CNT_INC_W'(LOCK_MAX)) && req[other]) begin
                        state_d = own_state(other);
                    end else if (cnt_inc >= CNT_INC_W'(LOCK_MAX)) begin
                        cnt_d = LOCK_CNT_W'(LOCK_MAX);
                    end else begin
                        cnt_d = cnt_inc[LOCK_CNT_W-1:0];
                    end
                end else if (req[other]) begin
                    state_d = own_state(other);
                end else if (!req[owner]) begin
                    state_d = IDLE;
                end else begin
                    // Unlocked transfer breaks the consecutive-lock run.
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
            if (state_d != IDLE) begin
                // Favour the other requester on the next tie.
                ptr_d = (state_d == OWN0);
            end
        end

        gnt_d  = {state_d == OWN1, state_d == OWN0};
        busy_d = (state_d != IDLE);
        if (xfer && !wr[owner]) begin
            rvalid_d[owner] = 1'b1;
        end
    end

    // State and registered outputs; reset discards any read in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= 1'b0;
            gnt_q    <= 2'b00;
            rvalid_q <= 2'b00;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            busy_q   <= busy_d;
        end
    end

    // Memory-side mux: owner's address/data while owned, zero when idle.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (owned) begin
            mem_addr  = owner ? addr1 : addr0;
            mem_wdata = owner ? wdata1 : wdata0;
        end
        mem_wr = xfer & wr[owner];
    end

    assign gnt    = gnt_q;
    assign rvalid = rvalid_q;
    assign busy   = busy_q;
    // Memory read data lands the cycle rvalid is high; pass it straight on.
    assign rdata  = mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, data word width.
REQ-002 Parameter: D_ADDR_W, 8, data memory address width.
REQ-003 Parameter: LOCK_MAX, 8, max consecutive locked transfers before forced release (2..255).
REQ-004 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req  input  2  per-requester access request; bit 0 = CPU controller, bit 1 = host/debug loader.
REQ-008 lock  input  2  per-requester hold-grant qualifier, sampled with req.
REQ-009 wr  input  2  per-requester write strobe (1 = write, 0 = read).
REQ-010 addr0, addr1  input  D_ADDR_W each  requester addresses.
REQ-011 wdata0, wdata1  input  WIDTH each  requester write data.
REQ-012 gnt  output  2  registered one-hot-or-zero grant.
REQ-013 rvalid  output  2  registered read-return strobe per requester.
REQ-014 rdata  output  WIDTH  read data, shared by both requesters; qualified by rvalid.
REQ-015 mem_addr  output  D_ADDR_W  to data memory.
REQ-016 mem_wr  output  1  memory write enable.
REQ-017 mem_wdata  output  WIDTH  memory write data.
REQ-018 mem_rdata  input  WIDTH  synchronous-read memory output, valid one cycle after address.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 FSM states: IDLE, OWN0, OWN1; gnt[i]=1 only in OWNi.
REQ-021 Transfer: occurs in any cycle with gnt[i]&req[i]; at most one transfer per cycle.
REQ-022 mem_addr/mem_wdata SHALL mux owner's addr/wdata in OWNi; drive 0 in IDLE; mem_wr = transfer & wr[owner].
REQ-023 Read transfer at cycle t: rvalid[owner]=1 at t+1 for exactly one cycle; rdata = mem_rdata at t+1.
REQ-024 Latency: req rising in IDLE at cycle t -> gnt at t+1 -> first transfer at t+1.
REQ-025 IDLE, single req[i]: next state OWNi.
REQ-026 IDLE, both req: next state OWN of requester not last served (rr pointer); the pointer updates on every entry to OWNi.
REQ-027 OWNi, req[i]&lock[i], lock count < LOCK_MAX: stay OWNi; count increments per locked transfer.
REQ-028 OWNi, locked transfers reach LOCK_MAX and req[j] set: next state OWNj; count clears.
REQ-029 OWNi, unlocked transfer or req[i] low: OWNj if req[j], else OWNi if req[i], else IDLE.
REQ-030 Every OWNi->OWNj switch SHALL be direct (no IDLE bubble); a loser waits at most LOCK_MAX+1 cycles.
REQ-031 Lock count clears on any state change; with no competitor, lock never forces release.
REQ-032 Writes SHALL never assert rvalid; rvalid bits SHALL be mutually exclusive.

Reset
REQ-033 reset low: state=IDLE, gnt=0, rvalid=0, lock count=0, rr pointer favours requester 0, immediately and asynchronously.
REQ-034 A read in flight when reset asserts SHALL be discarded (no rvalid after release).
REQ-035 First arbitration after reset release occurs on the first rising clk edge with reset high.

Structure
REQ-036 Shared package dmem_arb_pkg holds state enum (IDLE, OWN0, OWN1), default WIDTH/D_ADDR_W/LOCK_MAX constants.
REQ-037 One sub-module arb_rr_pick: combinational 2-way round-robin picker (req, pointer -> winner, valid).

Verification
REQ-038 Reset, req=01 wr=0 addr0=0x10, mem returns 0xBEEF: gnt=01 cycle 1, rvalid=01 rdata=0xBEEF cycle 2.
REQ-039 Both req from IDLE after reset, no lock: grants alternate 01,10,01,10 with no idle cycle.
REQ-040 req1 locked continuously, req0 asserted, LOCK_MAX=8: exactly 8 transfers to 1, then gnt=01.
REQ-041 Write req0 addr0=0x20 wdata0=0x1234 then read same address: mem_wr=1 one cycle, no rvalid on write, read returns 0x1234.
REQ-042 reset low the cycle after a read transfer: gnt=0 and rvalid=0 immediately; no rvalid after release.
REQ-043 Owner drops req with other idle: IDLE next cycle, busy=0, mem_wr=0, mem_addr=0.
